// File: rtl/video_types.sv
// Shared video timing constants and the LCD mode encoding used by the
// scan timer and the bus-side STAT logic.
package video_types;

    localparam int LCD_LINES       = 144;
    localparam int LCD_LINEWIDTH   = 160;
    localparam int DOTS_PER_LINE   = 456;
    localparam int LINES_PER_FRAME = 154;
    localparam int SCAN_START_DOT  = 80;
    localparam int OAM_DOTS        = 80;
    localparam int XFER_DOTS       = 172;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } LcdMode;

endpackage

// File: rtl/lcd_scan_timer_if.sv
// Framebuffer read port and serial pixel stream between the scan timer
// (master) and the framebuffer / display driver side (slave).
interface lcd_scan_timer_if;

    logic [7:0] pix_rd_line;
    logic [7:0] pix_rd_x;
    logic [1:0] pix_rd_data;
    logic       pix_valid;
    logic [1:0] pix_data;

    modport master (
        output pix_rd_line,
        output pix_rd_x,
        input  pix_rd_data,
        output pix_valid,
        output pix_data
    );

    modport slave (
        input  pix_rd_line,
        input  pix_rd_x,
        output pix_rd_data,
        input  pix_valid,
        input  pix_data
    );

endinterface

// File: rtl/lcd_dot_counter.sv
// Dot and line position counters for the LCD frame. The 'active' flag marks
// cycles where the position is meaningful; the first cycle after enable is
// always line 0, dot 0.
module lcd_dot_counter
    import video_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    output logic       active,
    output logic [8:0] dot,
    output logic [7:0] ly,
    output logic       line_end
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);

    // Advance one dot per clock; a disabled cycle parks the position at the frame origin
    always_ff @(posedge clk) begin
        if (reset || !lcd_en) begin
            active <= 1'b0;
            dot    <= '0;
            ly     <= '0;
        end else if (!active) begin
            active <= 1'b1;
            dot    <= '0;
            ly     <= '0;
        end else if (dot == LAST_DOT) begin
            dot <= '0;
            ly  <= (ly == LAST_LINE) ? 8'd0 : ly + 8'd1;
        end else begin
            dot <= dot + 9'd1;
        end
    end

    assign line_end = active && (dot == LAST_DOT);

endmodule

// File: rtl/lcd_scan_timer.sv
// LCD dot-clock timing generator and pixel scanout engine.
// Optional feature macro: LCD_STAT_IRQ_EN builds the STAT interrupt edge
// detector; without it stat_irq is tied low.
module lcd_scan_timer
    import video_types::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lcd_en,
    input  logic [7:0]            lyc,
    output logic                  drawline,
    output logic [7:0]            ly,
    output logic [1:0]            mode,
    output logic                  lyc_match,
    output logic                  vblank_irq,
    output logic                  stat_irq,
    output logic                  frame_start,
    output logic                  line_end,
    lcd_scan_timer_if.master      pix
);

    localparam logic [8:0] SCAN_FIRST = 9'(SCAN_START_DOT);
    localparam logic [8:0] SCAN_END   = 9'(SCAN_START_DOT + LCD_LINEWIDTH);
    localparam logic [8:0] XFER_FIRST = 9'(OAM_DOTS);
    localparam logic [8:0] HBL_FIRST  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] VBL_LINE   = 8'(LCD_LINES);

    logic       active;
    logic [8:0] dot;
    logic       visible;
    logic       line_start;
    logic       in_scan;
    LcdMode     cur_mode;

    lcd_dot_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .lcd_en   (lcd_en),
        .active   (active),
        .dot      (dot),
        .ly       (ly),
        .line_end (line_end)
    );

    assign visible    = ly < VBL_LINE;
    assign line_start = active && (dot == 9'd0);
    assign in_scan    = active && visible && (dot >= SCAN_FIRST) && (dot < SCAN_END);

    // Mode follows the dot position; idle timer reports HBlank
    always_comb begin
        cur_mode = MODE_HBLANK;
        if (active) begin
            if (!visible) begin
                cur_mode = MODE_VBLANK;
            end else if (dot < XFER_FIRST) begin
                cur_mode = MODE_OAM;
            end else if (dot < HBL_FIRST) begin
                cur_mode = MODE_XFER;
            end else begin
                cur_mode = MODE_HBLANK;
            end
        end
    end

    assign mode        = cur_mode;
    assign drawline    = line_start && visible;
    assign frame_start = line_start && (ly == 8'd0);
    assign vblank_irq  = line_start && (ly == VBL_LINE);
    assign lyc_match   = (ly == lyc);

    assign pix.pix_rd_line = in_scan ? ly : 8'd0;
    assign pix.pix_rd_x    = in_scan ? 8'(dot - SCAN_FIRST) : 8'd0;

    // Capture the framebuffer read one cycle after its address; dropping lcd_en clears it immediately
    always_ff @(posedge clk) begin
        if (reset || !lcd_en || !in_scan) begin
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= 2'd0;
        end else begin
            pix.pix_valid <= 1'b1;
            pix.pix_data  <= pix.pix_rd_data;
        end
    end

`ifdef LCD_STAT_IRQ_EN
    LcdMode prev_mode;
    logic   prev_match;

    // Remember last cycle's mode and compare result so entries and rises can be seen
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mode  <= MODE_HBLANK;
            prev_match <= 1'b0;
        end else begin
            prev_mode  <= cur_mode;
            prev_match <= lyc_match;
        end
    end

    assign stat_irq = active &&
                      (((cur_mode != prev_mode) && (cur_mode != MODE_XFER)) ||
                       (lyc_match && !prev_match));
`else
    assign stat_irq = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_scan_timer.sv
// Self-checking bench for lcd_scan_timer. Expected outputs are derived from
// the number of enabled cycles since the timer last started.
module tb_lcd_scan_timer;
    import video_types::*;

    localparam int FRAME_CYCLES = 456 * 154;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       lcd_en = 1'b0;
    logic [7:0] lyc    = 8'd10;
    logic       drawline, lyc_match, vblank_irq, stat_irq, frame_start, line_end;
    logic [7:0] ly;
    logic [1:0] mode;

    lcd_scan_timer_if pix_bus ();
    assign pix_bus.pix_rd_data = pix_bus.pix_rd_x[1:0];

    lcd_scan_timer dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .drawline    (drawline),
        .ly          (ly),
        .mode        (mode),
        .lyc_match   (lyc_match),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq),
        .frame_start (frame_start),
        .line_end    (line_end),
        .pix         (pix_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos = -1;
    bit checking = 1'b0;
    int seg = 0;
    int prev_mode = 0;
    int prev_match = 0;
    int l5_count = 0;
    int l5_first = -1;
    int l5_last = -1;
    int lyc_cycles = 0;
    int fs_count = 0;
    int dl_count = 0;
    int vb_count = 0;
    int fs3_count = 0;
    int vb3_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, exp);
            if (errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $fatal(1, "[TB] too many errors, stopping");
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [7:0] l, input int cycles);
        reset  = r;
        lcd_en = en;
        lyc    = l;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Enabled-cycle count since the timer last started; -1 while idle
    always @(posedge clk) begin
        if (reset || !lcd_en) pos <= -1;
        else pos <= pos + 1;
    end

    // Compare every output against the frame-position model on the falling edge
    always @(negedge clk) begin
        if (checking) begin
            int p, line, d, e_mode, e_match, e_stat, e_draw, e_fs, e_vb, e_le;
            int e_rline, e_rx, e_valid, e_data;
            bit act;
            act  = (pos >= 0);
            p    = act ? (pos % FRAME_CYCLES) : 0;
            line = p / 456;
            d    = p % 456;
            if (!act) e_mode = 0;
            else if (line >= 144) e_mode = 1;
            else if (d < 80) e_mode = 2;
            else if (d < 252) e_mode = 3;
            else e_mode = 0;
            e_draw  = (act && d == 0 && line < 144) ? 1 : 0;
            e_fs    = (act && d == 0 && line == 0) ? 1 : 0;
            e_vb    = (act && d == 0 && line == 144) ? 1 : 0;
            e_le    = (act && d == 455) ? 1 : 0;
            e_match = (line == int'(lyc)) ? 1 : 0;
            e_rline = (act && line < 144 && d >= 80 && d < 240) ? line : 0;
            e_rx    = (act && line < 144 && d >= 80 && d < 240) ? d - 80 : 0;
            e_valid = (act && line < 144 && d >= 81 && d <= 240) ? 1 : 0;
            e_data  = (e_valid == 1) ? (d - 81) % 4 : 0;
`ifdef LCD_STAT_IRQ_EN
            e_stat = (act && (((e_mode != prev_mode) && e_mode != 3) ||
                              (e_match == 1 && prev_match == 0))) ? 1 : 0;
`else
            e_stat = 0;
`endif
            checkOutput("ly", 32'(ly), line);
            checkOutput("mode", 32'(mode), e_mode);
            checkOutput("drawline", 32'(drawline), e_draw);
            checkOutput("frame_start", 32'(frame_start), e_fs);
            checkOutput("vblank_irq", 32'(vblank_irq), e_vb);
            checkOutput("line_end", 32'(line_end), e_le);
            checkOutput("lyc_match", 32'(lyc_match), e_match);
            checkOutput("stat_irq", 32'(stat_irq), e_stat);
            checkOutput("pix_rd_line", 32'(pix_bus.pix_rd_line), e_rline);
            checkOutput("pix_rd_x", 32'(pix_bus.pix_rd_x), e_rx);
            checkOutput("pix_valid", 32'(pix_bus.pix_valid), e_valid);
            checkOutput("pix_data", 32'(pix_bus.pix_data), e_data);

            if (seg == 1) begin
                if (pos == 79)   checkOutput("pin_mode_dot79", 32'(mode), 2);
                if (pos == 80)   checkOutput("pin_mode_dot80", 32'(mode), 3);
                if (pos == 251)  checkOutput("pin_mode_dot251", 32'(mode), 3);
                if (pos == 252)  checkOutput("pin_mode_dot252", 32'(mode), 0);
                if (pos == 455)  checkOutput("pin_line_end_dot455", 32'(line_end), 1);
                if (pos == 456)  checkOutput("pin_ly_line1", 32'(ly), 1);
                if (pos == 2365) checkOutput("pin_rd_x_line5", 32'(pix_bus.pix_rd_x), 5);
                if (pos == 2366) checkOutput("pin_pix_line5", 32'(pix_bus.pix_data), 1);
                if (lyc_match) lyc_cycles <= lyc_cycles + 1;
                if (act && line == 5 && pix_bus.pix_valid) begin
                    checkOutput("line5_pixel", 32'(pix_bus.pix_data), l5_count % 4);
                    l5_count <= l5_count + 1;
                    if (l5_first < 0) l5_first <= d;
                    l5_last <= d;
                end
            end
            if (seg == 2) begin
                if (pos == 65664) checkOutput("pin_mode_line144", 32'(mode), 1);
                if (pos == 65664) checkOutput("pin_vblank_line144", 32'(vblank_irq), 1);
                if (pos == 65744) checkOutput("pin_mode_line144_dot80", 32'(mode), 1);
                if (pos == 70223) checkOutput("pin_mode_line153_end", 32'(mode), 1);
                if (frame_start) fs_count <= fs_count + 1;
                if (drawline)    dl_count <= dl_count + 1;
                if (vblank_irq)  vb_count <= vb_count + 1;
            end
            if (seg == 3) begin
                if (frame_start) fs3_count <= fs3_count + 1;
                if (vblank_irq)  vb3_count <= vb3_count + 1;
            end
            prev_mode  <= e_mode;
            prev_match <= e_match;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        $display("[TB] reset released, enabling timer");

        seg = 1;
        applyStimulus(1'b0, 1'b1, 8'd10, 1);
        checkOutput("first_cycle_frame_start", 32'(frame_start), 1);
        checkOutput("first_cycle_drawline", 32'(drawline), 1);
        applyStimulus(1'b0, 1'b1, 8'd10, 23000);
        checkOutput("pre_drop_ly", 32'(ly), 50);
        checkOutput("line5_valid_count", l5_count, 160);
        checkOutput("line5_first_dot", l5_first, 81);
        checkOutput("line5_last_dot", l5_last, 240);
        checkOutput("lyc_match_cycles", lyc_cycles, 456);

        $display("[TB] dropping lcd_en at line 50, dot 200");
        seg = 0;
        applyStimulus(1'b0, 1'b0, 8'd10, 1);
        checkOutput("drop_ly", 32'(ly), 0);
        checkOutput("drop_mode", 32'(mode), 0);
        checkOutput("drop_pix_valid", 32'(pix_bus.pix_valid), 0);
        applyStimulus(1'b0, 1'b0, 8'd10, 4);

        seg = 2;
        applyStimulus(1'b0, 1'b1, 8'd10, 1);
        checkOutput("reenable_frame_start", 32'(frame_start), 1);
        checkOutput("reenable_drawline", 32'(drawline), 1);
        applyStimulus(1'b0, 1'b1, 8'd10, 9220);
        lyc = 8'd20;
        #1;
        checkOutput("lyc_change_same_cycle", 32'(lyc_match), 1);
        applyStimulus(1'b0, 1'b1, 8'd20, 59480);
        checkOutput("pre_reset_ly", 32'(ly), 150);
        checkOutput("frame_start_count", fs_count, 1);
        checkOutput("drawline_count", dl_count, 144);
        checkOutput("vblank_count", vb_count, 1);

        $display("[TB] asserting reset at line 150, dot 300");
        seg = 3;
        applyStimulus(1'b1, 1'b1, 8'd20, 1);
        checkOutput("rst_ly", 32'(ly), 0);
        checkOutput("rst_mode", 32'(mode), 0);
        checkOutput("rst_drawline", 32'(drawline), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst_vblank_irq", 32'(vblank_irq), 0);
        checkOutput("rst_stat_irq", 32'(stat_irq), 0);
        checkOutput("rst_line_end", 32'(line_end), 0);
        checkOutput("rst_lyc_match", 32'(lyc_match), 0);
        checkOutput("rst_pix_rd_line", 32'(pix_bus.pix_rd_line), 0);
        checkOutput("rst_pix_rd_x", 32'(pix_bus.pix_rd_x), 0);
        checkOutput("rst_pix_valid", 32'(pix_bus.pix_valid), 0);
        checkOutput("rst_pix_data", 32'(pix_bus.pix_data), 0);
        applyStimulus(1'b0, 1'b1, 8'd20, 600);
        checkOutput("post_reset_frame_start_count", fs3_count, 1);
        checkOutput("post_reset_vblank_count", vb3_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
